// File: rtl/aec_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aec_param: ASCII infix calculator (tokenise, shunting-yard, postfix eval) |
// | Macro AEC_DIV_EN adds an iterative unsigned '/' operator.      Rev 1.0    |
// +--------------------------------------------------------------------------+
module aec_param #(
  parameter int DATA_W    = 7,
  parameter int MAX_LEN   = 16,
  parameter int STK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic [7:0]        ascii_in,
  output logic              valid,
  output logic [DATA_W-1:0] result,
  output logic              error,
  output logic              busy
);
  localparam int TIW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SW  = $clog2(STK_DEPTH + 1);
  localparam int SIW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam int CW  = $clog2(DATA_W + 1);

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
                         OP_LP  = 3'd4, OP_RP  = 3'd5, OP_EQ  = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CONV, S_EVAL, S_DIV, S_DONE, S_ERR} state_t;
  typedef struct packed { logic is_op; logic [3:0] val; } tok_t;

  state_t            state_q, state_d;
  tok_t              tok_q  [MAX_LEN];
  tok_t              tok_d  [MAX_LEN];
  tok_t              pf_q   [MAX_LEN];
  tok_t              pf_d   [MAX_LEN];
  logic [2:0]        ostk_q [STK_DEPTH];
  logic [2:0]        ostk_d [STK_DEPTH];
  logic [DATA_W-1:0] vstk_q [STK_DEPTH];
  logic [DATA_W-1:0] vstk_d [STK_DEPTH];
  logic [TIW-1:0]    tcnt_q, tcnt_d, ci_q, ci_d, plen_q, plen_d, ei_q, ei_d;
  logic [SW-1:0]     osp_q, osp_d, vsp_q, vsp_d;

  logic              w_legal;
  tok_t              w_tok;
  logic [2:0]        w_otop;
  logic [DATA_W-1:0] w_va, w_vb;
  logic              w_ofull, w_vfull;

  assign w_otop  = ostk_q[SIW'(osp_q - 1'b1)];
  assign w_vb    = vstk_q[SIW'(vsp_q - 1'b1)];
  assign w_va    = vstk_q[SIW'(vsp_q - 2'd2)];
  assign w_ofull = (osp_q == SW'(STK_DEPTH));
  assign w_vfull = (vsp_q == SW'(STK_DEPTH));

  always_comb begin
    w_legal = 1'b1;
    w_tok   = '0;
    if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
      w_tok.val = 4'(ascii_in - 8'h30);
    end else if (ascii_in >= 8'h61 && ascii_in <= 8'h66) begin
      w_tok.val = 4'(ascii_in - 8'h57);
    end else begin
      w_tok.is_op = 1'b1;
      case (ascii_in)
        8'h2B:   w_tok.val = {1'b0, OP_ADD};
        8'h2D:   w_tok.val = {1'b0, OP_SUB};
        8'h2A:   w_tok.val = {1'b0, OP_MUL};
        8'h28:   w_tok.val = {1'b0, OP_LP};
        8'h29:   w_tok.val = {1'b0, OP_RP};
        8'h3D:   w_tok.val = {1'b0, OP_EQ};
`ifdef AEC_DIV_EN
        8'h2F:   w_tok.val = {1'b0, OP_DIV};
`endif
        default: w_legal = 1'b0;
      endcase
    end
  end

  function automatic logic prec(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a, b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return a * b;
    endcase
  endfunction

`ifdef AEC_DIV_EN
  // Restoring divider: dq holds the shifting dividend, which becomes the quotient.
  logic [DATA_W-1:0] dq_q, dq_d, dr_q, dr_d, dd_q, dd_d;
  logic [CW-1:0]     dcnt_q, dcnt_d;
  logic [DATA_W:0]   w_rsh;
  logic              w_ge;
  assign w_rsh = {dr_q, dq_q[DATA_W-1]};
  assign w_ge  = (w_rsh >= {1'b0, dd_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_q <= '0; dr_q <= '0; dd_q <= '0; dcnt_q <= '0;
    end else begin
      dq_q <= dq_d; dr_q <= dr_d; dd_q <= dd_d; dcnt_q <= dcnt_d;
    end
  end
`endif

  always_comb begin
    tok_t           tk;
    logic [TIW-1:0] idx;
    tk = '0;
    idx = '0;
    state_d = state_q;
    tok_d = tok_q; pf_d = pf_q; ostk_d = ostk_q; vstk_d = vstk_q;
    tcnt_d = tcnt_q; ci_d = ci_q; plen_d = plen_q; ei_d = ei_q;
    osp_d = osp_q; vsp_d = vsp_q;
`ifdef AEC_DIV_EN
    dq_d = dq_q; dr_d = dr_q; dd_d = dd_q; dcnt_d = dcnt_q;
`endif
    case (state_q)
      S_IDLE, S_READ: begin
        if (state_q == S_IDLE) begin
          tcnt_d = '0; ci_d = '0; plen_d = '0; ei_d = '0; osp_d = '0; vsp_d = '0;
        end else begin
          idx = tcnt_q;
        end
        if (state_q == S_READ || ready) begin
          if (!w_legal) begin
            state_d = S_ERR;
          end else begin
            tok_d[idx] = w_tok;
            tcnt_d     = idx + 1'b1;
            // The last buffer slot is reserved for the terminating '='.
            if (w_tok.is_op && w_tok.val[2:0] == OP_EQ) state_d = S_CONV;
            else if (idx == TIW'(MAX_LEN - 1))           state_d = S_ERR;
            else                                         state_d = S_READ;
          end
        end
      end
      S_CONV: begin
        tk = tok_q[ci_q];
        if (!tk.is_op) begin
          pf_d[plen_q] = tk; plen_d = plen_q + 1'b1; ci_d = ci_q + 1'b1;
        end else begin
          case (tk.val[2:0])
            OP_LP: begin
              if (w_ofull) state_d = S_ERR;
              else begin
                ostk_d[SIW'(osp_q)] = OP_LP; osp_d = osp_q + 1'b1; ci_d = ci_q + 1'b1;
              end
            end
            OP_RP: begin
              if (osp_q == '0) state_d = S_ERR;
              else if (w_otop == OP_LP) begin
                osp_d = osp_q - 1'b1; ci_d = ci_q + 1'b1;
              end else begin
                pf_d[plen_q] = {2'b10, w_otop}; plen_d = plen_q + 1'b1; osp_d = osp_q - 1'b1;
              end
            end
            OP_EQ: begin
              if (osp_q == '0) state_d = S_EVAL;
              else if (w_otop == OP_LP) state_d = S_ERR;
              else begin
                pf_d[plen_q] = {2'b10, w_otop}; plen_d = plen_q + 1'b1; osp_d = osp_q - 1'b1;
              end
            end
            default: begin
              if (osp_q != '0 && w_otop != OP_LP && prec(w_otop) >= prec(tk.val[2:0])) begin
                pf_d[plen_q] = {2'b10, w_otop}; plen_d = plen_q + 1'b1; osp_d = osp_q - 1'b1;
              end else if (w_ofull) begin
                state_d = S_ERR;
              end else begin
                ostk_d[SIW'(osp_q)] = tk.val[2:0]; osp_d = osp_q + 1'b1; ci_d = ci_q + 1'b1;
              end
            end
          endcase
        end
      end
      S_EVAL: begin
        tk = pf_q[ei_q];
        if (ei_q == plen_q) begin
          state_d = (vsp_q == SW'(1)) ? S_DONE : S_ERR;
        end else if (!tk.is_op) begin
          if (w_vfull) state_d = S_ERR;
          else begin
            vstk_d[SIW'(vsp_q)] = DATA_W'(tk.val); vsp_d = vsp_q + 1'b1; ei_d = ei_q + 1'b1;
          end
        end else if (vsp_q < SW'(2)) begin
          state_d = S_ERR;
`ifdef AEC_DIV_EN
        end else if (tk.val[2:0] == OP_DIV) begin
          if (w_vb == '0) state_d = S_ERR;
          else begin
            dq_d = w_va; dr_d = '0; dd_d = w_vb; dcnt_d = CW'(DATA_W); state_d = S_DIV;
          end
`endif
        end else begin
          vstk_d[SIW'(vsp_q - 2'd2)] = alu(tk.val[2:0], w_va, w_vb);
          vsp_d = vsp_q - 1'b1;
          ei_d  = ei_q + 1'b1;
        end
      end
`ifdef AEC_DIV_EN
      S_DIV: begin
        dr_d   = w_ge ? DATA_W'(w_rsh - {1'b0, dd_q}) : w_rsh[DATA_W-1:0];
        dq_d   = {dq_q[DATA_W-2:0], w_ge};
        dcnt_d = dcnt_q - 1'b1;
        if (dcnt_q == CW'(1)) begin
          vstk_d[SIW'(vsp_q - 2'd2)] = dq_d;
          vsp_d   = vsp_q - 1'b1;
          ei_d    = ei_q + 1'b1;
          state_d = S_EVAL;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tcnt_q <= '0; ci_q <= '0; plen_q <= '0; ei_q <= '0; osp_q <= '0; vsp_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        tok_q[i] <= '0; pf_q[i] <= '0;
      end
      for (int i = 0; i < STK_DEPTH; i++) begin
        ostk_q[i] <= '0; vstk_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      tcnt_q <= tcnt_d; ci_q <= ci_d; plen_q <= plen_d; ei_q <= ei_d;
      osp_q <= osp_d; vsp_q <= vsp_d;
      tok_q <= tok_d; pf_q <= pf_d; ostk_q <= ostk_d; vstk_q <= vstk_d;
    end
  end

  assign valid  = (state_q == S_DONE) || (state_q == S_ERR);
  assign error  = (state_q == S_ERR);
  assign result = (state_q == S_DONE) ? w_vb : '0;
  assign busy   = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_aec_param.sv
`default_nettype none
// tb_aec_param: directed and randomized expressions checked against a queue-based reference evaluator.
module tb_aec_param;
  localparam int DATA_W    = 7;
  localparam int MAX_LEN   = 16;
  localparam int STK_DEPTH = 8;
  localparam int MASK      = (1 << DATA_W) - 1;
`ifdef AEC_DIV_EN
  localparam int LAT = 3 * MAX_LEN + 4 + DATA_W * MAX_LEN;
`else
  localparam int LAT = 3 * MAX_LEN + 4;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ready = 1'b0;
  logic [7:0]        ascii_in = 8'h20;
  logic              valid, error, busy;
  logic [DATA_W-1:0] result;

  int n_vec = 0, n_cmp = 0, n_mis = 0, n_valid = 0, exp_valid = 0;
  int last_res = 0, last_err = 0;

  aec_param #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .STK_DEPTH(STK_DEPTH)) dut (
    .clk(clk), .rst(rst), .ready(ready), .ascii_in(ascii_in),
    .valid(valid), .result(result), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (valid) begin
      n_valid++;
      last_res = int'(result);
      last_err = int'(error);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_dig(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "f");
  endfunction

  function automatic int dig_val(input logic [7:0] c);
    return (c <= "9") ? int'(c) - 48 : int'(c) - 87;
  endfunction

  function automatic bit legal(input logic [7:0] c);
`ifdef AEC_DIV_EN
    if (c == "/") return 1'b1;
`endif
    return is_dig(c) || c == "+" || c == "-" || c == "*" || c == "(" || c == ")" || c == "=";
  endfunction

  function automatic int prec(input logic [7:0] c);
    return (c == "*" || c == "/") ? 1 : 0;
  endfunction

  // Reference: tokenise, convert to postfix, then evaluate, each on plain queues.
  function automatic void model(input string s, output bit err, output int res);
    logic [7:0] toks[$];
    logic [7:0] ops[$];
    logic [7:0] pf[$];
    int         vals[$];
    logic [7:0] c;
    int         a, b, r;
    err = 1'b1;
    res = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s.getc(i);
      if (!legal(c)) return;
      toks.push_back(c);
      if (c == "=") break;
      if (toks.size() == MAX_LEN) return;
    end
    if (toks[toks.size() - 1] != "=") return;
    foreach (toks[i]) begin
      c = toks[i];
      if (is_dig(c)) pf.push_back(c);
      else if (c == "(") begin
        if (ops.size() == STK_DEPTH) return;
        ops.push_back(c);
      end else if (c == ")") begin
        while (ops.size() > 0 && ops[ops.size() - 1] != "(") pf.push_back(ops.pop_back());
        if (ops.size() == 0) return;
        void'(ops.pop_back());
      end else if (c == "=") begin
        while (ops.size() > 0) begin
          if (ops[ops.size() - 1] == "(") return;
          pf.push_back(ops.pop_back());
        end
      end else begin
        while (ops.size() > 0 && ops[ops.size() - 1] != "(" && prec(ops[ops.size() - 1]) >= prec(c))
          pf.push_back(ops.pop_back());
        if (ops.size() == STK_DEPTH) return;
        ops.push_back(c);
      end
    end
    foreach (pf[i]) begin
      c = pf[i];
      if (is_dig(c)) begin
        if (vals.size() == STK_DEPTH) return;
        vals.push_back(dig_val(c) & MASK);
      end else begin
        if (vals.size() < 2) return;
        b = vals.pop_back();
        a = vals.pop_back();
        case (c)
          "+": r = a + b;
          "-": r = a - b;
          "*": r = a * b;
          default: begin
            if (b == 0) return;
            r = a / b;
          end
        endcase
        vals.push_back(r & MASK);
      end
    end
    if (vals.size() != 1) return;
    err = 1'b0;
    res = vals[0];
  endfunction

  function automatic string app(input string s, input logic [7:0] c);
    string      junk;
    logic [7:0] ch;
    junk = "g/ =)(x";
    ch = c;
    if ($urandom_range(0, 29) == 0) ch = junk.getc($urandom_range(0, 6));
    return $sformatf("%s%c", s, ch);
  endfunction

  function automatic string gen();
    string s, dg, op;
    int    depth, nops;
    dg = "0123456789abcdef";
`ifdef AEC_DIV_EN
    op = "+-*/";
`else
    op = "+-*";
`endif
    s = "";
    depth = 0;
    nops = $urandom_range(0, 5);
    for (int k = 0; k <= nops; k++) begin
      if (depth < 3 && $urandom_range(0, 3) == 0) begin s = app(s, "("); depth++; end
      s = app(s, dg.getc($urandom_range(0, 15)));
      if (depth > 0 && $urandom_range(0, 2) == 0) begin s = app(s, ")"); depth--; end
      if (k < nops) s = app(s, op.getc($urandom_range(0, op.len() - 1)));
    end
    while (depth > 0) begin s = app(s, ")"); depth--; end
    return {s, "="};
  endfunction

  task automatic run(input string s, input bit exp_err, input int exp_res, input string tag);
    int start, k;
    n_vec++;
    @(negedge clk);
    check({tag, "/busy_idle"}, int'(busy), 0);
    check({tag, "/valid_count"}, n_valid, exp_valid);
    start = n_valid;
    exp_valid = start + 1;
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) @(negedge clk);
      ready = (i == 0);
      ascii_in = s.getc(i);
    end
    @(negedge clk);
    ready = 1'b0;
    ascii_in = 8'h20;
    k = 0;
    while (n_valid == start && k < LAT) begin
      @(negedge clk);
      k++;
    end
    check({tag, "/valid_seen"}, int'(n_valid != start), 1);
    if (n_valid != start) begin
      check({tag, "/error"}, last_err, int'(exp_err));
      check({tag, "/result"}, last_res, exp_err ? 0 : exp_res);
    end
  endtask

  initial begin
    string s;
    bit    e;
    int    r;
    repeat (3) @(negedge clk);
    check("reset/valid", int'(valid), 0);
    check("reset/busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset/result", int'(result), 0);
    check("reset/error", int'(error), 0);

    run("2+3*4=", 0, 14, "prec");
    run("(2+3)*4=", 0, 20, "paren");
    run("f-(a-1)=", 0, 6, "b2b");
    run("1-2=", 0, 127, "wrap_sub");
    run("f*f=", 0, 97, "wrap_mul");
    run("(1+2=", 1, 0, "open_paren");
    run("1+2)=", 1, 0, "close_paren");
    run("1+=", 1, 0, "underflow");
    run("1g2=", 1, 0, "illegal");
    run("12=", 1, 0, "two_left");
    run("=", 1, 0, "empty");
    run("123456789abcdef12", 1, 0, "too_long");
    run("1+2+3+4+5+6+7+8=", 0, 36, "max_len");
    run("(((((((((1=", 1, 0, "ostk_ovf");
    run("2*(3-5)-1=", 0, 123, "mixed");

    // Abort an expression with reset; it must produce no valid.
    @(negedge clk);
    ready = 1'b1; ascii_in = "1";
    @(negedge clk);
    ready = 1'b0; ascii_in = "+";
    @(negedge clk);
    ascii_in = "2";
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    ascii_in = "=";
    @(negedge clk);
    ascii_in = 8'h20;
    repeat (LAT) @(negedge clk);
    check("rst_abort/valid_count", n_valid, exp_valid);
    check("rst_abort/busy", int'(busy), 0);
    run("9=", 0, 9, "after_rst");

`ifdef AEC_DIV_EN
    run("f/2=", 0, 7, "div");
    run("8/(2-2)=", 1, 0, "div_zero");
    run("1+7*9/4=", 0, 16, "div_prec");
`else
    run("f/2=", 1, 0, "div_illegal");
`endif

    for (int n = 0; n < 80; n++) begin
      s = gen();
      model(s, e, r);
      run(s, e, r, $sformatf("rnd%0d:%s", n, s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
